// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows an external ALU each cycle.
// Define MULDIV_ABORT_EN to let a pipeline flush abandon an in-flight operation.
module muldiv_sequencer #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] DBZ_LO = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [4:0]       alu_conf,
    output logic             alu_sign,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_NOR = 5'b01100;

    typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, ITER, FIX_LO, FIX_HI, DONE} state_t;

    state_t           state, next_state;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] opnd;
    logic             is_div, is_sgn, neg_q, neg_r;
    logic             accept, abort, div_zero;
    logic [WIDTH-1:0] rs_sh;
    logic             carry, ge;

`ifdef MULDIV_ABORT_EN
    assign abort  = flush && (state != IDLE);
    assign accept = start && (state == IDLE) && !flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign abort  = 1'b0;
    assign accept = start && (state == IDLE);
`endif

    assign div_zero = op[1] && (rt == '0);
    assign rs_sh    = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign carry    = alu_result < hi;
    assign ge       = hi[WIDTH-1] | (rs_sh >= opnd);
    assign alu_sign = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        alu_conf   = ALU_ADD;
        alu_in1    = '0;
        alu_in2    = '0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (div_zero)   next_state = DONE;
                    else if (op[0]) next_state = ABS_A;
                    else            next_state = ITER;
                end
            end
            // Operand a lives in lo for divide, in opnd for multiply; b is the other one.
            ABS_A: begin
                alu_conf   = ALU_SUB;
                alu_in2    = is_div ? lo : opnd;
                next_state = ABS_B;
            end
            ABS_B: begin
                alu_conf   = ALU_SUB;
                alu_in2    = is_div ? opnd : lo;
                next_state = ITER;
            end
            ITER: begin
                if (is_div) begin
                    alu_conf = ALU_SUB;
                    alu_in1  = rs_sh;
                    alu_in2  = opnd;
                end else begin
                    alu_in1 = hi;
                    alu_in2 = lo[0] ? opnd : '0;
                end
                if (cnt == 5'(WIDTH - 1)) next_state = is_sgn ? FIX_LO : DONE;
            end
            FIX_LO: begin
                alu_conf   = ALU_SUB;
                alu_in2    = lo;
                next_state = FIX_HI;
            end
            // Negated 64-bit product: hi only takes the +1 carry when the low word is zero.
            FIX_HI: begin
                if (is_div || lo == '0) begin
                    alu_conf = ALU_SUB;
                    alu_in2  = hi;
                end else begin
                    alu_conf = ALU_NOR;
                    alu_in1  = hi;
                end
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            is_sgn <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (accept) begin
            is_div <= op[1];
            is_sgn <= op[0];
            neg_q  <= rs[WIDTH-1] ^ rt[WIDTH-1];
            neg_r  <= rs[WIDTH-1];
            cnt    <= '0;
            if (div_zero) begin
                hi <= rs;
                lo <= DBZ_LO;
            end else if (op[1]) begin
                hi   <= '0;
                lo   <= rs;
                opnd <= rt;
            end else begin
                hi   <= '0;
                lo   <= rt;
                opnd <= rs;
            end
        end else if (!abort) begin
            case (state)
                ABS_A: begin
                    if (is_div) begin
                        if (lo[WIDTH-1]) lo <= alu_result;
                    end else if (opnd[WIDTH-1]) opnd <= alu_result;
                end
                ABS_B: begin
                    if (is_div) begin
                        if (opnd[WIDTH-1]) opnd <= alu_result;
                    end else if (lo[WIDTH-1]) lo <= alu_result;
                end
                ITER: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        hi <= ge ? alu_result : rs_sh;
                        lo <= {lo[WIDTH-2:0], ge};
                    end else begin
                        hi <= {carry, alu_result[WIDTH-1:1]};
                        lo <= {alu_result[0], lo[WIDTH-1:1]};
                    end
                end
                FIX_LO: if (neg_q) lo <= alu_result;
                FIX_HI: if (is_div ? neg_r : neg_q) hi <= alu_result;
                default: ;
            endcase
        end
    end

endmodule
